// File: rtl/button_conditioner.sv
// Pushbutton front end: two-flop synchronizer, counter debounce, press/release
// pulses and per-channel auto-repeat for the stopwatch controller.
module button_conditioner #(
  parameter int NUM_BTN         = 6,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_RATE     = 10000000,
  parameter int CNT_W           = 27
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_BTN-1:0] btn_raw,
  input  logic [NUM_BTN-1:0] repeat_en,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release,
  output logic [NUM_BTN-1:0] btn_repeat
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DELAY  = 2'd1;
  localparam logic [1:0] ST_REPEAT = 2'd2;

  localparam logic [CNT_W-1:0] DB_TC  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RD_TC  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RR_TC  = CNT_W'(REPEAT_RATE - 1);

  logic [NUM_BTN-1:0] sync_a;
  logic [NUM_BTN-1:0] sync_s;
  logic [CNT_W-1:0]   dcnt  [NUM_BTN];
  logic [CNT_W-1:0]   rcnt  [NUM_BTN];
  logic [1:0]         state [NUM_BTN];

  logic [NUM_BTN-1:0] accept;
  logic [NUM_BTN-1:0] level_nxt;

  // accept marks the cycle a level change is committed; the FSM looks at
  // level_nxt so a release beats a repeat terminal count in the same cycle.
  always_comb begin
    // NOTE: default every combinational output before the loop so no path
    // leaves a bit unassigned and infers a latch.
    accept    = '0;
    level_nxt = btn_level;
    for (int i = 0; i < NUM_BTN; i++) begin
      accept[i] = (sync_s[i] != btn_level[i]) && (dcnt[i] == DB_TC);
      if (accept[i]) level_nxt[i] = sync_s[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_a      <= '0;
      sync_s      <= '0;
      btn_level   <= '0;
      btn_press   <= '0;
      btn_release <= '0;
      btn_repeat  <= '0;
      for (int i = 0; i < NUM_BTN; i++) begin
        dcnt[i]  <= '0;
        rcnt[i]  <= '0;
        state[i] <= ST_IDLE;
      end
    end else begin
      sync_a      <= btn_raw;
      sync_s      <= sync_a;
      btn_level   <= level_nxt;
      btn_press   <= accept & sync_s;
      btn_release <= accept & ~sync_s;

      for (int i = 0; i < NUM_BTN; i++) begin
        if ((sync_s[i] == btn_level[i]) || accept[i]) dcnt[i] <= '0;
        else                                          dcnt[i] <= dcnt[i] + 1'b1;

        btn_repeat[i] <= 1'b0;
        if (!level_nxt[i]) begin
          state[i] <= ST_IDLE;
          rcnt[i]  <= '0;
        end else begin
          case (state[i])
            ST_IDLE: begin
              // Only reachable with level_nxt high on the accepted press.
              btn_repeat[i] <= 1'b1;
              rcnt[i]       <= '0;
              state[i]      <= ST_DELAY;
            end
            ST_DELAY: begin
              if (!repeat_en[i]) begin
                rcnt[i] <= '0;
              end else if (rcnt[i] == RD_TC) begin
                btn_repeat[i] <= 1'b1;
                rcnt[i]       <= '0;
                state[i]      <= ST_REPEAT;
              end else begin
                rcnt[i] <= rcnt[i] + 1'b1;
              end
            end
            ST_REPEAT: begin
              if (!repeat_en[i]) begin
                rcnt[i]  <= '0;
                state[i] <= ST_DELAY;
              end else if (rcnt[i] == RR_TC) begin
                btn_repeat[i] <= 1'b1;
                rcnt[i]       <= '0;
              end else begin
                rcnt[i] <= rcnt[i] + 1'b1;
              end
            end
            default: begin
              state[i] <= ST_IDLE;
              rcnt[i]  <= '0;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench: directed timeline scenarios plus randomized buttons,
// all compared against a timestamp-based reference model of the conditioner.
module tb_button_conditioner;

  localparam int NB = 2;
  localparam int D  = 4;
  localparam int RD = 10;
  localparam int RR = 3;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [NB-1:0] btn_raw;
  logic [NB-1:0] repeat_en;
  logic [NB-1:0] btn_level;
  logic [NB-1:0] btn_press;
  logic [NB-1:0] btn_release;
  logic [NB-1:0] btn_repeat;

  button_conditioner #(
    .NUM_BTN(NB), .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD),
    .REPEAT_RATE(RR), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset(reset), .btn_raw(btn_raw), .repeat_en(repeat_en),
    .btn_level(btn_level), .btn_press(btn_press),
    .btn_release(btn_release), .btn_repeat(btn_repeat)
  );

  initial forever #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int base     = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d rel=%0d got=%0h expected=%0h", tag, cyc, cyc - base, got, exp);
    end
  endtask

  // Reference model: raw history through a 2-deep delay, debounce by the
  // timestamp at which s began to disagree, repeat by age since press or
  // since repeat_en was last seen low.
  bit          m_ff1 [NB];
  bit          m_s   [NB];
  bit          m_lvl [NB];
  int          m_dstart [NB];
  int          m_anchor [NB];
  logic [NB-1:0] e_lvl, e_press, e_rel, e_rep;

  task automatic model_edge();
    if (reset) begin
      for (int i = 0; i < NB; i++) begin
        m_ff1[i] = 0; m_s[i] = 0; m_lvl[i] = 0;
        m_dstart[i] = -1; m_anchor[i] = 0;
      end
      e_lvl = '0; e_press = '0; e_rel = '0; e_rep = '0;
    end else begin
      for (int i = 0; i < NB; i++) begin
        bit acc;
        int age;
        acc = 0;
        if (m_s[i] == m_lvl[i]) m_dstart[i] = -1;
        else begin
          if (m_dstart[i] < 0) m_dstart[i] = cyc;
          if (cyc - m_dstart[i] + 1 == D) begin
            acc = 1;
            m_dstart[i] = -1;
          end
        end
        e_press[i] = acc && m_s[i];
        e_rel[i]   = acc && !m_s[i];
        if (acc) m_lvl[i] = m_s[i];
        e_lvl[i] = m_lvl[i];

        if (!m_lvl[i]) e_rep[i] = 0;
        else if (e_press[i]) begin
          m_anchor[i] = cyc;
          e_rep[i]    = 1;
        end else if (!repeat_en[i]) begin
          m_anchor[i] = cyc;
          e_rep[i]    = 0;
        end else begin
          age      = cyc - m_anchor[i];
          e_rep[i] = (age >= RD) && ((age - RD) % RR == 0);
        end

        m_s[i]   = m_ff1[i];
        m_ff1[i] = btn_raw[i];
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
    check("level",   32'(btn_level),   32'(e_lvl));
    check("press",   32'(btn_press),   32'(e_press));
    check("release", 32'(btn_release), 32'(e_rel));
    check("repeat",  32'(btn_repeat),  32'(e_rep));
    check("press_and_release", 32'(btn_press & btn_release), 32'd0);
  endtask

  // Reset for 3 edges; timeline restarts so the deassert cycle is rel 3.
  task automatic restart();
    reset   = 1'b1;
    btn_raw = '0;
    repeat (3) tick();
    base  = cyc - 3;
    reset = 1'b0;
  endtask

  int r;
  int hold [NB];

  initial begin
    reset = 1'b1; btn_raw = '0; repeat_en = '0;

    // Clean press, auto-repeat, release.
    repeat_en = 2'b01;
    restart();
    while (cyc - base < 50) begin
      tick(); r = cyc - base;
      check("s1_rep", 32'(btn_repeat[0]), 32'(r inside {16, 26, 29, 32, 35, 38, 41, 44}));
      if (r == 16) check("s1_press16", 32'(btn_press[0]), 32'd1);
      if (r == 15) check("s1_level15", 32'(btn_level[0]), 32'd0);
      if (r == 46) check("s1_release46", 32'(btn_release[0]), 32'd1);
      if (r == 10) btn_raw[0] = 1'b1;
      if (r == 40) btn_raw[0] = 1'b0;
    end

    // repeat_en dropped at 27, raised at 35.
    repeat_en = 2'b01;
    restart();
    while (cyc - base < 50) begin
      tick(); r = cyc - base;
      check("s2_rep", 32'(btn_repeat[0]), 32'(r inside {16, 26, 45, 48}));
      if (r == 10) btn_raw[0] = 1'b1;
      if (r == 27) repeat_en[0] = 1'b0;
      if (r == 35) repeat_en[0] = 1'b1;
    end

    // Reset mid-operation with the button held.
    repeat_en = 2'b00;
    restart();
    while (cyc - base < 40) begin
      tick(); r = cyc - base;
      if (r == 16) check("s3_level16", 32'(btn_level[0]), 32'd1);
      if (r == 21 || r == 22)
        check("s3_rst_outs", {btn_level, btn_press, btn_release, btn_repeat}, 32'd0);
      if (r > 21) check("s3_press", 32'(btn_press[0]), 32'(r == 28));
      check("s3_rep_eq_press", 32'(btn_repeat), 32'(btn_press));
      if (r == 10) btn_raw[0] = 1'b1;
      if (r == 20) reset = 1'b1;
      if (r == 22) reset = 1'b0;
    end

    // Bounce on press, clean release, then a 3-cycle glitch.
    restart();
    while (cyc - base < 56) begin
      tick(); r = cyc - base;
      check("s4_press",   32'(btn_press[0]),   32'(r == 20));
      check("s4_release", 32'(btn_release[0]), 32'(r == 36));
      case (r)
        10, 12, 14, 40: btn_raw[0] = 1'b1;
        11, 13, 30, 43: btn_raw[0] = 1'b0;
        default: ;
      endcase
    end

    // Independent channels: joint press, glitch on channel 1 only.
    restart();
    while (cyc - base < 40) begin
      tick(); r = cyc - base;
      if (r == 16) check("s5_joint_press", 32'(btn_press), 32'd3);
      if (r >= 16) check("s5_ch0_level", 32'(btn_level[0]), 32'd1);
      if (r == 10) btn_raw = 2'b11;
      if (r == 20) btn_raw[1] = 1'b0;
      if (r == 22) btn_raw[1] = 1'b1;
    end

    // Randomized buttons, enables and occasional resets.
    restart();
    for (int i = 0; i < NB; i++) hold[i] = 1;
    repeat (3000) begin
      tick();
      for (int i = 0; i < NB; i++) begin
        hold[i]--;
        if (hold[i] <= 0) begin
          btn_raw[i] = ~btn_raw[i];
          hold[i] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3))
                                                : int'($urandom_range(4, 40));
        end
        if ($urandom_range(0, 19) == 0) repeat_en[i] = ~repeat_en[i];
      end
      reset = ($urandom_range(0, 299) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Front-end stage between the Basys3 pushbuttons and the stopwatch controller.
- Turns raw asynchronous, bouncing button inputs (start, stop, lap, reset, set, up) into clean signals the controller can sample once per clk:
  - synchronized, debounced levels;
  - single-cycle press and release pulses;
  - optional auto-repeat pulses for held buttons.
- Each button channel is independent and identical.

Parameters:
- NUM_BTN, 6, number of button channels.
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles needed to accept a level change (10 ms at 100 MHz). Must be >= 2.
- REPEAT_DELAY, 50000000, cycles from the accepted press to the first auto-repeat pulse (0.5 s). Must be >= 2.
- REPEAT_RATE, 10000000, cycles between later auto-repeat pulses (0.1 s). Must be >= 2.
- CNT_W, 27, width of the per-channel counters. Must hold max(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_RATE).

Ports:
- clk, input, 1, system clock (100 MHz).
- reset, input, 1, synchronous, active-high.
- btn_raw, input, NUM_BTN, raw asynchronous button pins, 1 = pressed.
- repeat_en, input, NUM_BTN, per-channel auto-repeat enable, synchronous to clk.
- btn_level, output, NUM_BTN, debounced registered level.
- btn_press, output, NUM_BTN, one-cycle pulse when btn_level rises.
- btn_release, output, NUM_BTN, one-cycle pulse when btn_level falls.
- btn_repeat, output, NUM_BTN, one-cycle pulse on press and on each auto-repeat.

Behaviour:
- Reset:
  - While reset = 1 at a clk edge, clear all synchronizer flops, counters, state and outputs to 0.
  - A button held through reset is treated as a new press: after reset deasserts, it is accepted DEBOUNCE_CYCLES cycles after the synchronizer output goes high.
- Synchronizer:
  - Two-flop chain per channel; s = second flop.
  - Raw change to s change: 2 cycles.
- Debounce, per channel, with debounce counter dcnt:
  - If s == btn_level: dcnt <= 0.
  - Otherwise dcnt <= dcnt + 1.
  - When dcnt == DEBOUNCE_CYCLES-1 and s != btn_level: btn_level <= s and dcnt <= 0.
  - Result: a level change is accepted only after s has differed from btn_level for DEBOUNCE_CYCLES consecutive cycles. Any shorter glitch or bounce run resets dcnt and has no effect.
  - Total latency from a clean raw edge to btn_level: 2 + DEBOUNCE_CYCLES cycles.
- Pulses:
  - btn_press is high in the same cycle btn_level first reads 1; btn_release likewise when it first reads 0.
  - Each is exactly 1 cycle wide.
  - btn_press and btn_release on one channel are never high together.
- Auto-repeat FSM, per channel, with repeat counter rcnt:
  - IDLE: btn_level = 0. On the btn_press cycle, btn_repeat = 1. Go to DELAY with rcnt = 0.
  - DELAY: rcnt increments each cycle.
    - If rcnt reaches REPEAT_DELAY-1 and repeat_en = 1: pulse btn_repeat, rcnt <= 0, go to REPEAT.
  - REPEAT: rcnt increments each cycle.
    - If rcnt reaches REPEAT_RATE-1 and repeat_en = 1: pulse btn_repeat, rcnt <= 0.
  - From any state, if btn_level = 0: go to IDLE, rcnt <= 0, no repeat pulse that cycle.
  - From DELAY or REPEAT, if repeat_en = 0: rcnt <= 0 and go to DELAY. No pulses while repeat_en stays 0. When repeat_en returns to 1, the full REPEAT_DELAY restarts.
  - Release-vs-terminal-count collision: if release and the terminal count land in the same cycle, release wins and no repeat pulse is issued.
  - With repeat_en = 0 throughout, btn_repeat == btn_press.
- Channels:
  - Fully independent.
  - Simultaneous presses on several channels give simultaneous pulses with no priority or masking.
- Counter width: counters never wrap. They are cleared at terminal count, and CNT_W is sized to fit.

Test Plan (sim parameters DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=3, NUM_BTN=2):
- Clean press: btn_raw[0] 0->1 at cycle 10, held. btn_level[0] and btn_press[0] rise at cycle 16. btn_press[0] is high for cycle 16 only; btn_repeat[0] pulses at 16.
- Bounce rejection: raw[0] toggles 1,0,1,0 at 1-cycle spacing, then stays 1. No output until s has been stable 1 for 4 cycles, then exactly one btn_press[0]. A 3-cycle glitch alone produces no output at all.
- Auto-repeat: with repeat_en[0] = 1 and the press accepted at cycle 16, btn_repeat[0] pulses at 16, 26, 29, 32, ...
  - Release: raw low at cycle 40 gives btn_release[0] at 46 and no repeat pulses after release.
- repeat_en toggle: repeat_en[0] is dropped at cycle 27 and raised at 35 while held. No pulses from 27 to 34; next pulse at cycle 45.
- Reset mid-operation: reset held for cycles 20-21 while btn_raw[0] = 1 and btn_level[0] = 1.
  - All outputs read 0 from cycle 21.
  - btn_press[0] pulses again 2 + 4 cycles after reset deasserts.
- Independent channels: raw[0] and raw[1] rise together. btn_press[0] and btn_press[1] pulse in the same cycle. A later glitch on raw[1] does not affect channel 0.
